st_splitter_fifo: RTL and testbench

- Parametrised Avalon-ST 1-to-N packet splitter; successor to the fixed 16-bit, 2-output splitter in the sensor_algo qsys streaming path.
- Broadcasts each input beat to every enabled output through a per-output show-ahead FIFO, so a briefly slow consumer does not stall the others until its FIFO fills.
- Adds a per-packet output enable mask and a sticky protocol-error flag.

---
 rtl/st_splitter_fifo.sv | 182 ++++++++++++++++++
 tb/tb_st_splitter_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st_splitter_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | st_splitter_fifo                                                          |
// | Avalon-ST 1-to-N packet splitter with per-output show-ahead FIFOs,        |
// | per-packet output enable mask and sticky protocol-error flag.             |
// | Optional: ST_SPLITTER_PKT_CNT_EN adds a 32-bit end-of-packet counter.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module st_splitter_fifo #(
    parameter int DATA_W     = 16,
    parameter int EMPTY_W    = 1,
    parameter int NUM_OUT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        st_splitter_clk_clk,
    input  logic                        st_splitter_reset_reset_n,
    output logic                        st_splitter_in_ready,
    input  logic                        st_splitter_in_valid,
    input  logic                        st_splitter_in_startofpacket,
    input  logic                        st_splitter_in_endofpacket,
    input  logic [EMPTY_W-1:0]          st_splitter_in_empty,
    input  logic [DATA_W-1:0]           st_splitter_in_data,
    input  logic [NUM_OUT-1:0]          st_splitter_out_enable,
    input  logic [NUM_OUT-1:0]          st_splitter_out_ready,
    output logic [NUM_OUT-1:0]          st_splitter_out_valid,
    output logic [NUM_OUT-1:0]          st_splitter_out_startofpacket,
    output logic [NUM_OUT-1:0]          st_splitter_out_endofpacket,
    output logic [NUM_OUT*EMPTY_W-1:0]  st_splitter_out_empty,
    output logic [NUM_OUT*DATA_W-1:0]   st_splitter_out_data,
    output logic                        st_splitter_proto_err
`ifdef ST_SPLITTER_PKT_CNT_EN
    ,
    output logic [31:0]                 st_splitter_pkt_count
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 2 + EMPTY_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    logic                clk;
    logic                rst_n;
    state_t              state;
    state_t              state_next;
    logic [NUM_OUT-1:0]  active_mask;
    logic [NUM_OUT-1:0]  active_mask_next;
    logic [NUM_OUT-1:0]  write_mask;
    logic [NUM_OUT-1:0]  not_full;
    logic                accept;
    logic                set_err;
    logic                proto_err;
    logic [ENTRY_W-1:0]  in_entry;

    assign clk   = st_splitter_clk_clk;
    assign rst_n = st_splitter_reset_reset_n;

    // The mask latched at SOP governs the body of a packet; a new packet
    // (or a stray beat outside a packet) uses the live enable.
    assign write_mask = (state == IN_PKT) ? active_mask : st_splitter_out_enable;

    assign st_splitter_in_ready = rst_n & (&(~write_mask | not_full));
    assign accept   = st_splitter_in_valid & st_splitter_in_ready;
    assign in_entry = {st_splitter_in_startofpacket, st_splitter_in_endofpacket,
                       st_splitter_in_empty, st_splitter_in_data};

    always_comb begin
        state_next       = state;
        active_mask_next = active_mask;
        set_err          = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!st_splitter_in_startofpacket) begin
                        set_err = 1'b1;
                    end else if (!st_splitter_in_endofpacket) begin
                        state_next       = IN_PKT;
                        active_mask_next = st_splitter_out_enable;
                    end
                end
                IN_PKT: begin
                    if (st_splitter_in_startofpacket) begin
                        set_err          = 1'b1;
                        active_mask_next = st_splitter_out_enable;
                    end
                    if (st_splitter_in_endofpacket) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            active_mask <= '0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_next;
            active_mask <= active_mask_next;
            proto_err   <= proto_err | set_err;
        end
    end

    assign st_splitter_proto_err = proto_err;

    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_fifo
            logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]   wr_ptr;
            logic [PTR_W-1:0]   rd_ptr;
            logic [CNT_W-1:0]   count;
            logic               push;
            logic               pop;
            logic               has_data;
            logic [ENTRY_W-1:0] shown;

            assign has_data    = (count != '0);
            assign push        = accept & write_mask[i];
            assign pop         = has_data & st_splitter_out_ready[i];
            assign not_full[i] = (count != DEPTH_CNT);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    case ({push, pop})
                        2'b10:   count <= count + CNT_W'(1);
                        2'b01:   count <= count - CNT_W'(1);
                        default: count <= count;
                    endcase
                end
            end

            // Storage needs no reset: nothing is shown unless count says so.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr] <= in_entry;
                end
            end

            assign shown = has_data ? mem[rd_ptr] : '0;

            assign st_splitter_out_valid[i]                        = has_data;
            assign st_splitter_out_startofpacket[i]                = shown[ENTRY_W-1];
            assign st_splitter_out_endofpacket[i]                  = shown[ENTRY_W-2];
            assign st_splitter_out_empty[i*EMPTY_W +: EMPTY_W]     = shown[DATA_W +: EMPTY_W];
            assign st_splitter_out_data[i*DATA_W +: DATA_W]        = shown[DATA_W-1:0];
        end
    endgenerate

`ifdef ST_SPLITTER_PKT_CNT_EN
    logic [31:0] pkt_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (accept && st_splitter_in_endofpacket) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end

    assign st_splitter_pkt_count = pkt_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_st_splitter_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_st_splitter_fifo                                                       |
// | Scoreboard bench: per-output expected-beat queues fed from accepted input |
// | beats, drained by a monitor on every output handshake.                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_st_splitter_fifo;

    localparam int DATA_W  = 16;
    localparam int EMPTY_W = 1;
    localparam int NUM_OUT = 2;
    localparam int DEPTH   = 4;
    localparam int EW      = 2 + EMPTY_W + DATA_W;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       in_ready;
    logic                       in_valid = 1'b0;
    logic                       in_sop = 1'b0;
    logic                       in_eop = 1'b0;
    logic [EMPTY_W-1:0]         in_empty = '0;
    logic [DATA_W-1:0]          in_data = '0;
    logic [NUM_OUT-1:0]         out_enable = '1;
    logic [NUM_OUT-1:0]         out_ready = '1;
    logic [NUM_OUT-1:0]         out_valid;
    logic [NUM_OUT-1:0]         out_sop;
    logic [NUM_OUT-1:0]         out_eop;
    logic [NUM_OUT*EMPTY_W-1:0] out_empty;
    logic [NUM_OUT*DATA_W-1:0]  out_data;
    logic                       proto_err;
`ifdef ST_SPLITTER_PKT_CNT_EN
    logic [31:0]                pkt_count;
`endif

    st_splitter_fifo #(
        .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .NUM_OUT(NUM_OUT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .st_splitter_clk_clk          (clk),
        .st_splitter_reset_reset_n    (rst_n),
        .st_splitter_in_ready         (in_ready),
        .st_splitter_in_valid         (in_valid),
        .st_splitter_in_startofpacket (in_sop),
        .st_splitter_in_endofpacket   (in_eop),
        .st_splitter_in_empty         (in_empty),
        .st_splitter_in_data          (in_data),
        .st_splitter_out_enable       (out_enable),
        .st_splitter_out_ready        (out_ready),
        .st_splitter_out_valid        (out_valid),
        .st_splitter_out_startofpacket(out_sop),
        .st_splitter_out_endofpacket  (out_eop),
        .st_splitter_out_empty        (out_empty),
        .st_splitter_out_data         (out_data),
        .st_splitter_proto_err        (proto_err)
`ifdef ST_SPLITTER_PKT_CNT_EN
        ,
        .st_splitter_pkt_count        (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: expected contents of each output FIFO plus packet state.
    logic [EW-1:0]      expq [NUM_OUT][$];
    bit                 m_in_pkt = 1'b0;
    logic [NUM_OUT-1:0] m_mask = '0;
    bit                 m_err = 1'b0;
    logic [31:0]        m_pkt = '0;
    int                 acc_cnt = 0;
    int                 rx_cnt [NUM_OUT];

    int                 rmode = 0;
    logic [NUM_OUT-1:0] rforce = '1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [NUM_OUT-1:0] wm;
        logic [EW-1:0]      e;
        bit                 exp_rdy;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_flags", {out_sop, out_eop, out_empty}, 0);
            for (int i = 0; i < NUM_OUT; i++) expq[i].delete();
            m_in_pkt = 1'b0;
            m_mask   = '0;
            m_err    = 1'b0;
            m_pkt    = '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++)
                chk($sformatf("out_valid[%0d]", i), out_valid[i], expq[i].size() != 0);
            wm = m_in_pkt ? m_mask : out_enable;
            exp_rdy = 1'b1;
            for (int i = 0; i < NUM_OUT; i++)
                if (wm[i] && expq[i].size() >= DEPTH) exp_rdy = 1'b0;
            chk("in_ready", in_ready, exp_rdy);
            chk("proto_err", proto_err, m_err);
`ifdef ST_SPLITTER_PKT_CNT_EN
            chk("pkt_count", pkt_count, m_pkt);
`endif
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_valid[i] && out_ready[i] && expq[i].size() != 0) begin
                    e = expq[i].pop_front();
                    chk($sformatf("beat[%0d]", i),
                        {out_sop[i], out_eop[i], out_empty[i*EMPTY_W +: EMPTY_W],
                         out_data[i*DATA_W +: DATA_W]}, e);
                    rx_cnt[i]++;
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                for (int i = 0; i < NUM_OUT; i++)
                    if (wm[i]) expq[i].push_back({in_sop, in_eop, in_empty, in_data});
                if (in_eop) m_pkt = m_pkt + 32'd1;
                if (!m_in_pkt) begin
                    if (!in_sop) m_err = 1'b1;
                    else if (!in_eop) begin
                        m_in_pkt = 1'b1;
                        m_mask   = out_enable;
                    end
                end else begin
                    if (in_sop) begin
                        m_err  = 1'b1;
                        m_mask = out_enable;
                    end
                    if (in_eop) m_in_pkt = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       out_ready = '1;
            1:       out_ready = NUM_OUT'($urandom);
            default: out_ready = rforce;
        endcase
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input bit sop, input bit eop, input logic [DATA_W-1:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = EMPTY_W'($urandom);
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [NUM_OUT-1:0] en);
        out_enable = en;
        for (int b = 0; b < len; b++)
            send_beat(b == 0, b == len - 1, DATA_W'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int a0, r0, r1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // basic broadcast 0x0001..0x0004
        rmode = 0;
        out_enable = 2'b11;
        for (int b = 0; b < 4; b++)
            send_beat(b == 0, b == 3, DATA_W'(b + 1));
        idle(5);

        // backpressure on output 1
        rmode = 2; rforce = 2'b01;
        a0 = acc_cnt; r0 = rx_cnt[0]; r1 = rx_cnt[1];
        fork
            begin
                out_enable = 2'b11;
                for (int b = 0; b < 6; b++)
                    send_beat(b == 0, b == 5, DATA_W'(16'h0100 + b));
            end
            begin
                idle(20);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_accepted", acc_cnt - a0, 4);
                chk("bp_out0_rx", rx_cnt[0] - r0, 4);
                chk("bp_out1_rx", rx_cnt[1] - r1, 0);
                rmode = 0;
            end
        join
        idle(10);
        chk("bp_out0_total", rx_cnt[0] - r0, 6);
        chk("bp_out1_total", rx_cnt[1] - r1, 6);

        // enable change mid-packet is ignored until the next SOP
        r1 = rx_cnt[1];
        out_enable = 2'b01;
        send_beat(1, 0, 16'h0A01);
        out_enable = 2'b11;
        send_beat(0, 0, 16'h0A02);
        send_beat(0, 1, 16'h0A03);
        idle(4);
        chk("mask_out1_none", rx_cnt[1] - r1, 0);
        send_pkt(2, 2'b11);
        idle(4);
        chk("mask_next_pkt_out1", rx_cnt[1] - r1, 2);

        // protocol error: SOP missing while idle
        chk("proto_err_clear", proto_err, 0);
        out_enable = 2'b11;
        send_beat(0, 0, 16'hBAD0);
        @(negedge clk);
        chk("proto_err_set", proto_err, 1);
        @(posedge clk); #1;
        send_pkt(3, 2'b11);
        send_pkt(1, 2'b10);
        idle(4);
        chk("proto_err_sticky", proto_err, 1);

        // reset with three beats buffered
        rmode = 2; rforce = 2'b00;
        out_enable = 2'b11;
        send_beat(1, 0, 16'h0C01);
        send_beat(0, 0, 16'h0C02);
        send_beat(0, 0, 16'h0C03);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rmode = 0;
        idle(2);
        chk("post_rst_proto_err", proto_err, 0);
        send_pkt(3, 2'b11);
        idle(5);

        // randomized traffic
        for (int p = 0; p < 60; p++) begin
            int len;
            rmode = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 5));
            out_enable = NUM_OUT'($urandom);
            for (int b = 0; b < len; b++) begin
                send_beat(b == 0, b == len - 1, DATA_W'($urandom));
                if ($urandom_range(0, 3) == 0) out_enable = NUM_OUT'($urandom);
            end
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
        end
        rmode = 0;
        idle(20);
        for (int i = 0; i < NUM_OUT; i++)
            chk($sformatf("drained[%0d]", i), expq[i].size(), 0);

`ifdef ST_SPLITTER_PKT_CNT_EN
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        send_pkt(2, 2'b11);
        send_pkt(1, 2'b01);
        send_pkt(3, 2'b10);
        idle(3);
        chk("pkt_count_three", pkt_count, 3);
        force dut.pkt_count = 32'hFFFF_FFFF;
        #1 release dut.pkt_count;
        m_pkt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        send_pkt(2, 2'b11);
        idle(2);
        chk("pkt_count_wrap", pkt_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial for (int i = 0; i < NUM_OUT; i++) rx_cnt[i] = 0;

endmodule
`default_nettype wire
